// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame reader: FSM encoding,
// pixel/address widths, default WS2812 timing, and the per-channel dimmer.
package led_pkg;

    localparam int PIX_W  = 24;
    localparam int ADDR_W = 8;

    localparam int DEF_N_LEDS  = 20;
    localparam int DEF_BIT_CYC = 15;
    localparam int DEF_T0H_CYC = 4;
    localparam int DEF_T1H_CYC = 8;
    localparam int DEF_RST_CYC = 960;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_SEND,
        ST_LATCH
    } state_t;

    // Logical right shift of each 8-bit colour channel by sh.
    function automatic logic [PIX_W-1:0] dim_word(input logic [PIX_W-1:0] w,
                                                  input logic [1:0] sh);
        logic [PIX_W-1:0] r;
        for (int i = 0; i < 3; i++) r[i*8 +: 8] = w[i*8 +: 8] >> sh;
        return r;
    endfunction

endpackage

// File: rtl/led_frame_reader_if.sv
// Pattern ROM read port: registered address/read-enable from the reader,
// read data returned by the ROM two edges after the enable is seen.
interface led_frame_reader_if;
    import led_pkg::*;

    logic [ADDR_W-1:0] o_addr;
    logic              o_ren;
    logic [PIX_W-1:0]  i_data;

    modport master (output o_addr, output o_ren, input i_data);
    modport slave  (input o_addr, input o_ren, output i_data);
endinterface

// File: rtl/ws2812_bit_tx.sv
// One WS2812 bit cell: a strobe starts a BIT_CYC-long period whose high time
// is chosen by i_bit, which must stay stable for the whole period.
// o_bit_end is high in the last cycle so the next strobe lands with no gap.
module ws2812_bit_tx #(
    parameter int BIT_CYC = 15,
    parameter int T0H_CYC = 4,
    parameter int T1H_CYC = 8
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_stb,
    input  logic i_bit,
    output logic o_dout,
    output logic o_bit_end
);
    localparam int CW = $clog2(BIT_CYC);

    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] hi_len;

    assign cnt_inc   = cnt + CW'(1);
    assign hi_len    = i_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
    assign o_bit_end = active && (cnt == CW'(BIT_CYC - 1));

    // Cycle counter and registered line level for the current bit cell.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            o_dout <= 1'b0;
        end else if (i_stb) begin
            active <= 1'b1;
            cnt    <= '0;
            o_dout <= 1'b1;
        end else if (o_bit_end) begin
            active <= 1'b0;
            o_dout <= 1'b0;
        end else if (active) begin
            cnt    <= cnt_inc;
            o_dout <= (cnt_inc < hi_len);
        end
    end

endmodule

// File: rtl/led_frame_reader.sv
// Reads N_LEDS GRB words from the pattern ROM starting at i_base and sends
// them MSB first as a WS2812 stream, followed by an RST_CYC latch gap.
// The next pixel is prefetched during bit 12 so pixels run back to back.
// Optional build macro LED_READER_DIM_EN adds the i_dim channel dimmer.
module led_frame_reader
    import led_pkg::*;
#(
    parameter int N_LEDS  = DEF_N_LEDS,
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int RST_CYC = DEF_RST_CYC
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
`ifdef LED_READER_DIM_EN
    input  logic [1:0]        i_dim,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_dout,
    led_frame_reader_if.master rom
);
    localparam int         LW       = $clog2(RST_CYC) + 1;
    localparam logic [7:0] LAST_PIX = 8'(N_LEDS - 1);

    state_t            state, state_nxt;
    logic [2:0]        vld_pipe;          // [0] is o_ren; [2] marks the capture edge
    logic [ADDR_W-1:0] addr_q, addr_d, base_q;
    logic [PIX_W-1:0]  shreg, hold, cap_word;
    logic [4:0]        bit_idx;
    logic [7:0]        pix;
    logic [LW-1:0]     latch_cnt;
    logic              ren_d, busy_d, done_d, tx_stb, bit_end;
    logic              start_ok, last_pix, frame_end, latch_done;

    assign rom.o_addr = addr_q;
    assign rom.o_ren  = vld_pipe[0];

    assign start_ok   = (state == ST_IDLE) && i_start;
    assign last_pix   = (pix == LAST_PIX);
    assign frame_end  = bit_end && (bit_idx == 5'd0) && last_pix;
    assign latch_done = (latch_cnt == LW'(RST_CYC - 1));

`ifdef LED_READER_DIM_EN
    logic [1:0] dim_q;

    // Dim amount is held for the whole frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      dim_q <= 2'd0;
        else if (start_ok) dim_q <= i_dim;
    end

    assign cap_word = dim_word(rom.i_data, dim_q);
`else
    assign cap_word = rom.i_data;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (i_start)    state_nxt = ST_FETCH;
            ST_FETCH:                 state_nxt = ST_WAIT;
            ST_WAIT:                  state_nxt = ST_LOAD;
            ST_LOAD:                  state_nxt = ST_SEND;
            ST_SEND:  if (frame_end)  state_nxt = ST_LATCH;
            ST_LATCH: if (latch_done) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the bit-cell strobe.
    always_comb begin
        ren_d  = 1'b0;
        addr_d = addr_q;
        busy_d = o_busy;
        done_d = 1'b0;
        tx_stb = 1'b0;
        if (start_ok) begin
            ren_d  = 1'b1;
            addr_d = i_base;
            busy_d = 1'b1;
        end
        // Prefetch the next pixel as bit 12 of the current one begins.
        if (state == ST_SEND && bit_end && bit_idx == 5'd13 && !last_pix) begin
            ren_d  = 1'b1;
            addr_d = base_q + pix + 8'd1;
        end
        if (state == ST_LOAD || (state == ST_SEND && bit_end && !frame_end))
            tx_stb = 1'b1;
        if (state == ST_LATCH && latch_done) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    // Output registers, ROM read pipeline, shift/holding registers, counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe  <= '0;
            addr_q    <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            base_q    <= '0;
            hold      <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            pix       <= '0;
            latch_cnt <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], ren_d};
            addr_q   <= addr_d;
            o_busy   <= busy_d;
            o_done   <= done_d;
            if (start_ok)    base_q <= i_base;
            if (vld_pipe[2]) hold   <= cap_word;
            if (state == ST_LOAD) begin
                shreg   <= cap_word;
                bit_idx <= 5'd23;
                pix     <= 8'd0;
            end else if (state == ST_SEND && bit_end) begin
                if (bit_idx == 5'd0) begin
                    shreg   <= hold;
                    bit_idx <= 5'd23;
                    pix     <= pix + 8'd1;
                end else begin
                    shreg   <= {shreg[PIX_W-2:0], 1'b0};
                    bit_idx <= bit_idx - 5'd1;
                end
            end
            latch_cnt <= (state == ST_LATCH) ? latch_cnt + LW'(1) : '0;
        end
    end

    // The current bit is always the shift register MSB.
    ws2812_bit_tx #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC)
    ) u_tx (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_stb     (tx_stb),
        .i_bit     (shreg[PIX_W-1]),
        .o_dout    (o_dout),
        .o_bit_end (bit_end)
    );

endmodule

// File: tb/tb_led_frame_reader.sv
// Bench for led_frame_reader: ROM model on the read port, a line monitor,
// and a frame-level reference (address sequence, decoded words, timing).
module tb_led_frame_reader;
    localparam int N = 20, BITC = 8, T0H = 2, T1H = 5, RSTC = 50;
    localparam int NB = N * 24;
    localparam int L  = NB * BITC + RSTC;

    logic       i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
    logic [7:0] i_base = 8'd0;
    logic [1:0] i_dim = 2'd0;
    logic       o_busy, o_done, o_dout;

    led_frame_reader_if bus();

    led_frame_reader #(.N_LEDS(N), .BIT_CYC(BITC), .T0H_CYC(T0H), .T1H_CYC(T1H),
                       .RST_CYC(RSTC)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_base  (i_base),
`ifdef LED_READER_DIM_EN
        .i_dim   (i_dim),
`endif
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_dout  (o_dout),
        .rom     (bus)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0, checks = 0;

    // Synchronous ROM: enable seen on one edge, data driven after the next.
    logic [23:0] rom [256];
    logic        r1 = 1'b0, dv = 1'b0;
    logic [7:0]  a1 = 8'd0;
    logic [23:0] rd = 24'd0;
    always @(posedge i_clk) begin
        r1 <= bus.o_ren;
        a1 <= bus.o_addr;
        dv <= r1;
        rd <= rom[a1];
    end
    assign bus.i_data = dv ? rd : 24'hxxxxxx;

    // Line monitor, sampled 1 ns after each rising edge.
    bit         cap_en = 1'b0;
    bit         dout_q[$];
    logic [7:0] aq[$];
    int         ndone = 0;
    always begin
        @(posedge i_clk);
        #1;
        if (cap_en) begin
            dout_q.push_back(o_dout);
            if (bus.o_ren) aq.push_back(bus.o_addr);
            if (o_done) ndone++;
        end
    end

    int          dq0, aq0, nd0;
    logic [23:0] got_w [N];

    function automatic logic [23:0] exp_word(input logic [7:0] b, input logic [1:0] d, input int k);
        logic [23:0] w;
        w = rom[(int'(b) + k) % 256];
`ifdef LED_READER_DIM_EN
        for (int ch = 0; ch < 3; ch++) w[ch*8 +: 8] = w[ch*8 +: 8] >> d;
`else
        if (d != 2'd0) w = w;
`endif
        return w;
    endfunction

    // Issue a start at the current negedge; checks the first registered outputs.
    task automatic start_frame(input logic [7:0] b, input logic [1:0] d);
        cap_en  = 1'b1;
        dq0     = dout_q.size();
        aq0     = aq.size();
        nd0     = ndone;
        i_base  = b;
        i_dim   = d;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++;
        if ({bus.o_ren, o_busy} !== 2'b11)
            $display("FAIL start_accept: ren,busy=%b%b required 11", bus.o_ren, o_busy);
        if ({bus.o_ren, o_busy} !== 2'b11) errors++;
    endtask

    // Wait for o_done, then check the whole frame against the reference.
    task automatic finish_frame(input string nm, input logic [7:0] b, input logic [1:0] d, input bit mid);
        bit got = 1'b0;
        int r = -1, dl, badw, badd, bada, h;
        logic [23:0] w;
        for (int c = 0; c < L + 200; c++) begin
            @(negedge i_clk);
            if (mid) i_start = (c == 300 || c == 2000);
            if (o_done) begin got = 1'b1; break; end
        end
        i_start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no o_done within %0d cycles", nm, L + 200);
            return;
        end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: %b required 0", nm, o_busy); end
        dl = dout_q.size() - 1;
        for (int i = dq0; i <= dl; i++) if (dout_q[i]) begin r = i; break; end
        checks++;
        if (r - dq0 !== 3) begin errors++; $display("FAIL %s first_rise: %0d cycles after start, required 3", nm, r - dq0); end
        checks++;
        if (dl - r !== L) begin errors++; $display("FAIL %s frame_len: %0d required %0d", nm, dl - r, L); end
        if (r < 0 || r + NB * BITC > dl) return;
        badw = 0; badd = 0;
        for (int k = 0; k < N; k++) begin
            w = 24'd0;
            for (int bt = 0; bt < 24; bt++) begin
                h = 0;
                for (int j = 0; j < BITC; j++) begin
                    if (dout_q[r + (k * 24 + bt) * BITC + j]) begin
                        if (j != h) badw++;
                        h++;
                    end
                end
                if (h != T0H && h != T1H) badw++;
                w = {w[22:0], (h == T1H)};
            end
            got_w[k] = w;
            if (w !== exp_word(b, d, k)) badd++;
        end
        for (int i = r + NB * BITC; i <= dl; i++) if (dout_q[i]) badw++;
        checks++;
        if (badw !== 0) begin errors++; $display("FAIL %s waveform: %0d bad cells required 0", nm, badw); end
        checks++;
        if (badd !== 0) begin errors++; $display("FAIL %s words: %0d wrong (word0=%h model %h)", nm, badd, got_w[0], exp_word(b, d, 0)); end
        checks++;
        if (aq.size() - aq0 !== N) begin errors++; $display("FAIL %s ren_count: %0d required %0d", nm, aq.size() - aq0, N); end
        bada = 0;
        for (int k = 0; k < N && aq0 + k < aq.size(); k++)
            if (aq[aq0 + k] !== 8'((int'(b) + k) % 256)) bada++;
        checks++;
        if (bada !== 0) begin errors++; $display("FAIL %s addr_seq: %0d wrong (first=%0d) required base %0d", nm, bada, aq[aq0], b); end
        checks++;
        if (ndone - nd0 !== 1) begin errors++; $display("FAIL %s done_count: %0d required 1", nm, ndone - nd0); end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({o_busy, o_done, bus.o_ren, o_dout, bus.o_addr} !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b ren=%b dout=%b addr=%0d required all 0",
                     o_busy, o_done, bus.o_ren, o_dout, bus.o_addr);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_pattern();
        int bad0 = 0, bad1 = 0;
        start_frame(8'd0, 2'd0);
        finish_frame("base0", 8'd0, 2'd0, 1'b0);
        for (int k = 0; k < N; k++) if (got_w[k] !== (k < 10 ? 24'h000F00 : 24'h000000)) bad0++;
        checks++;
        if (bad0 !== 0) begin errors++; $display("FAIL base0_pattern: %0d words off, word0=%h required 000f00", bad0, got_w[0]); end
        start_frame(8'd100, 2'd0);
        finish_frame("base100", 8'd100, 2'd0, 1'b0);
        for (int k = 0; k < N; k++) if (got_w[k] !== (k < 10 ? 24'h000000 : 24'h00000F)) bad1++;
        checks++;
        if (bad1 !== 0) begin errors++; $display("FAIL base100_pattern: %0d words off, word10=%h required 00000f", bad1, got_w[10]); end
    endtask

    task automatic test_wrap();
        start_frame(8'd250, 2'd0);
        finish_frame("wrap", 8'd250, 2'd0, 1'b0);
        checks++;
        if (aq[aq0 + 6] !== 8'd0) begin errors++; $display("FAIL wrap_addr6: %0d required 0", aq[aq0 + 6]); end
    endtask

    task automatic test_mid_start();
        start_frame(8'd3, 2'd0);
        finish_frame("mid_start", 8'd3, 2'd0, 1'b1);
        repeat (5) @(negedge i_clk);
        checks++;
        if ({o_busy, bus.o_ren} !== 2'b00) begin errors++; $display("FAIL mid_start_queued: busy,ren=%b%b required 00", o_busy, bus.o_ren); end
    endtask

    task automatic test_reset_abort();
        start_frame(8'd0, 2'd0);
        repeat (3 + 5 * 24 * BITC + 40) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, bus.o_ren, o_dout, bus.o_addr} !== 12'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b ren=%b dout=%b addr=%0d required all 0",
                     o_busy, o_done, bus.o_ren, o_dout, bus.o_addr);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        start_frame(8'd0, 2'd0);
        finish_frame("after_abort", 8'd0, 2'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        start_frame(8'd5, 2'd0);
        finish_frame("b2b_a", 8'd5, 2'd0, 1'b0);
        start_frame(8'd60, 2'd0);
        finish_frame("b2b_b", 8'd60, 2'd0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [1:0] d;
        for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
        for (int f = 0; f < 2; f++) begin
            b = 8'($urandom_range(0, 255));
`ifdef LED_READER_DIM_EN
            d = 2'($urandom_range(0, 3));
`else
            d = 2'd0;
`endif
            @(negedge i_clk);
            start_frame(b, d);
            finish_frame("random", b, d, 1'b0);
        end
    endtask

`ifdef LED_READER_DIM_EN
    task automatic test_dim();
        rom[30] = 24'h00F0FF;
        @(negedge i_clk);
        start_frame(8'd30, 2'd2);
        finish_frame("dim", 8'd30, 2'd2, 1'b0);
        checks++;
        if (got_w[0] !== 24'h003C3F) begin errors++; $display("FAIL dim_word: %h required 003c3f", got_w[0]); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'd0;
        for (int i = 0; i < 10; i++) rom[i] = 24'h000F00;
        for (int i = 110; i < 120; i++) rom[i] = 24'h00000F;
        test_reset();
        test_pattern();
        test_wrap();
        test_mid_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef LED_READER_DIM_EN
        test_dim();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_frame_reader.md
# led_frame_reader

Reads one frame of 24-bit GRB pixel words from the synchronous pattern ROM and shifts them out as a WS2812-style single-wire LED data stream. The block is the ROM's consumer. It drives the ROM's address and read-enable, captures each registered ROM word, and serializes it MSB first with a latch gap at the end of the frame. It sits between the VU-level control logic, which selects the frame base address (for example 0 for the red bar and 100 for the blue bar), and the LED strip pin.

## Interface
Parameters:
- N_LEDS, 20: pixels per frame, range 1..256.
- BIT_CYC, 15: clocks per data bit, minimum 4.
- T0H_CYC, 4: high clocks for a 0 bit.
- T1H_CYC, 8: high clocks for a 1 bit. Requires T0H_CYC < T1H_CYC < BIT_CYC.
- RST_CYC, 960: low clocks for the latch gap after the last bit.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - i_clk  in  1  system clock
  - i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  frame request, sampled only in IDLE
- i_base  in  8  ROM address of pixel 0, captured on accepted start
- o_busy  out  1  high from accepted start until the latch gap ends
- o_done  out  1  one-cycle pulse at frame end
- o_addr  out  8  ROM address, registered
- o_ren  out  1  ROM read enable, registered, one-cycle pulses only
- i_data  in  24  ROM read data, valid on the second edge after an o_ren edge, undriven otherwise
- o_dout  out  1  LED serial data

## Operation
- FSM states: IDLE, FETCH, WAIT, LOAD, SEND, LATCH.
- Transitions:
  - IDLE → FETCH on i_start. FETCH drives o_ren=1 and o_addr=base.
  - FETCH → WAIT → LOAD. LOAD captures i_data into the shift register.
  - LOAD → SEND. SEND shifts out 24 bits.
  - SEND → LATCH after the last bit of the last pixel.
  - LATCH → IDLE after RST_CYC clocks.
- Bit waveform: o_dout is high for T1H_CYC (bit=1) or T0H_CYC (bit=0) clocks, then low until BIT_CYC clocks.
- Prefetch:
  - While sending pixel k < N_LEDS-1, at the start of bit index 12, o_ren pulses for one cycle with o_addr = base+k+1.
  - i_data is captured two edges later into a 24-bit holding register.
  - At the end of bit 0, the shift register loads from the holding register. There is no inter-pixel gap.
- Address arithmetic is 8-bit modulo 256: base+k wraps, e.g. 255 → 0.
- i_data is sampled only at the defined capture edge. The block never samples i_data while it is undriven.
- i_start while busy is ignored and not queued.
- Reset values: o_busy=0, o_done=0, o_addr=0, o_ren=0, o_dout=0, FSM=IDLE. Reset mid-frame aborts immediately with o_dout low; no partial latch handling is performed.

## Timing
- Start latency: i_start is sampled at edge S.
  - After S: o_ren=1, o_busy=1.
  - After S+1: o_ren=0.
  - Edge S+2 (WAIT→LOAD): i_data is valid from the ROM.
  - Edge S+3: word captured. o_dout rises after S+3.
- Frame length from the first o_dout rise to the o_done pulse: N_LEDS·24·BIT_CYC + RST_CYC clocks.
- o_done and the o_busy fall occur on the same edge. A new i_start is accepted the next cycle.
- o_ren pulses exactly N_LEDS times per frame.

## Configuration
- LED_READER_DIM_EN:
  - Defined: adds port i_dim (in, 2), captured on accepted start. Each 8-bit channel of every word is logically right-shifted by i_dim before loading.
  - Undefined: the port is absent and words are sent unchanged.

## Structure
- Package led_pkg: FSM state encoding, PIX_W=24, ADDR_W=8, default timing constants.
- Sub-module ws2812_bit_tx: takes a bit and a strobe, generates one BIT_CYC waveform, and asserts bit_end. The parent owns the FSM, address counter, prefetch and shift registers.

## Test plan
- ROM model loaded with addresses 0–9 = 0x000F00 and 10–19 = 0; i_base=0, N_LEDS=20 → decoded stream is 10×0x000F00 followed by 10×0x000000. o_ren address sequence is 0..19. Frame length matches the formula.
- i_base=100 with the same ROM pattern → 10×0 then 10×0x00000F. No gap between pixels; every bit period is exactly BIT_CYC.
- i_base=250, N_LEDS=10 → addresses 250..255 then 0..3.
- i_start pulsed mid-frame → ignored. Exactly one o_done; o_ren count = N_LEDS.
- i_rst_n low during pixel 5 → all outputs 0 asynchronously. A new start then sends a full correct frame.
- With LED_READER_DIM_EN defined, i_dim=2 and word 0x00F0FF → 0x003C3F transmitted.
